axi_ctrl_regfile: RTL

Parametrised AXI4-Lite control slave with XRT-compatible register map, replacing the fixed two-argument/one-result example slave. Provides NUM_ARGS writable 32-bit scalar arguments, NUM_RESULTS read-only result registers captured from the kernel, an ap_start/ap_done/ap_ready/ap_idle handshake to a user kernel, auto-restart, and a level interrupt. Sits between the host-facing s_axi_control port and the kernel datapath.

---
 rtl/axi_ctrl_regfile.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_ctrl_regfile.sv
// -----------------------------------------------------------------------------
// axi_ctrl_regfile
//
// AXI4-Lite control slave with an XRT-compatible register map. Exposes
// NUM_ARGS writable 32-bit scalar arguments and NUM_RESULTS read-only result
// registers. It drives the ap_start/ap_ready/ap_done/ap_idle handshake to a
// user kernel, supports auto-restart, and raises a level interrupt.
//
// Register map (byte addresses; bits [1:0] of the address are ignored):
//   0x000 CTRL  bit0 ap_start   (W1 sets, W0 ignored)
//               bit1 ap_done    (RO, clear-on-read)
//               bit2 ap_idle    (live input)
//               bit3 ap_ready   (RO, clear-on-read)
//               bit7 auto_restart (RW)
//   0x004 GIER  bit0 global interrupt enable
//   0x008 IER   bit0 done enable, bit1 ready enable
//   0x00C ISR   bit0 done, bit1 ready; writing 1 toggles the bit
//   0x010 + 4*i                argument i   (RW, byte enables honoured)
//   0x010 + 4*NUM_ARGS + 4*j   result j     (RO, captured on ap_done)
//   Any other address returns SLVERR.
//
// Ports:
//   aclk, areset             clock; synchronous active-high reset
//   s_axi_control_aw* / w* / b* / ar* / r*   AXI4-Lite slave channels
//   ap_start   out  start request, held until ap_ready
//   ap_ready   in   one-cycle pulse, kernel accepted its arguments
//   ap_done    in   one-cycle pulse, kernel finished; results are valid
//   ap_idle    in   kernel idle level
//   args       out  argument i on bits [32i+31:32i]
//   results    in   result j on bits [32j+31:32j], sampled on ap_done
//   interrupt  out  GIER[0] & |ISR[1:0]
// -----------------------------------------------------------------------------
module axi_ctrl_regfile #(
  parameter int ADDR_W      = 12,
  parameter int NUM_ARGS    = 2,
  parameter int NUM_RESULTS = 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  // Write address channel
  input  logic [ADDR_W-1:0]        s_axi_control_awaddr,
  input  logic                     s_axi_control_awvalid,
  output logic                     s_axi_control_awready,
  // Write data channel
  input  logic [31:0]              s_axi_control_wdata,
  input  logic [3:0]               s_axi_control_wstrb,
  input  logic                     s_axi_control_wvalid,
  output logic                     s_axi_control_wready,
  // Write response channel
  output logic [1:0]               s_axi_control_bresp,
  output logic                     s_axi_control_bvalid,
  input  logic                     s_axi_control_bready,
  // Read address channel
  input  logic [ADDR_W-1:0]        s_axi_control_araddr,
  input  logic                     s_axi_control_arvalid,
  output logic                     s_axi_control_arready,
  // Read data channel
  output logic [31:0]              s_axi_control_rdata,
  output logic [1:0]               s_axi_control_rresp,
  output logic                     s_axi_control_rvalid,
  input  logic                     s_axi_control_rready,
  // Kernel handshake
  output logic                     ap_start,
  input  logic                     ap_ready,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  output logic [32*NUM_ARGS-1:0]   args,
  input  logic [32*NUM_RESULTS-1:0] results,
  output logic                     interrupt
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word indices (byte address >> 2).
  localparam int unsigned CTRL_IDX = 0;
  localparam int unsigned GIER_IDX = 1;
  localparam int unsigned IER_IDX  = 2;
  localparam int unsigned ISR_IDX  = 3;
  localparam int unsigned ARG_BASE = 4;
  localparam int unsigned RES_BASE = ARG_BASE + NUM_ARGS;
  localparam int unsigned MAP_END  = RES_BASE + NUM_RESULTS;

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic              ready_en_q;   // low in reset, opens the address channels
  logic              aw_valid_q;
  logic              w_valid_q;
  logic [ADDR_W-3:0] aw_word_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic        ap_start_q;
  logic        done_q;
  logic        ready_q;
  logic        auto_restart_q;
  logic        gie_q;
  logic [1:0]  ier_q;
  logic [1:0]  isr_q;
  logic [31:0] args_q    [NUM_ARGS];
  logic [31:0] results_q [NUM_RESULTS];

  // Low address bits carry no information for word-aligned registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

  // Each address channel accepts at most one beat until the response is done.
  assign s_axi_control_awready = ready_en_q & ~aw_valid_q & ~bvalid_q;
  assign s_axi_control_wready  = ready_en_q & ~w_valid_q  & ~bvalid_q;
  assign s_axi_control_arready = ready_en_q & ~rvalid_q;

  assign s_axi_control_bvalid = bvalid_q;
  assign s_axi_control_bresp  = bresp_q;
  assign s_axi_control_rvalid = rvalid_q;
  assign s_axi_control_rresp  = rresp_q;
  assign s_axi_control_rdata  = rdata_q;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s_axi_control_awvalid & s_axi_control_awready;
  assign w_hs  = s_axi_control_wvalid  & s_axi_control_wready;
  assign ar_hs = s_axi_control_arvalid & s_axi_control_arready;

  // ---------------------------------------------------------------------------
  // Write decode: a write commits on the cycle both AW and W are latched.
  // ---------------------------------------------------------------------------
  logic        wr_commit;
  int unsigned wr_idx;
  logic        wr_ctrl, wr_gier, wr_ier, wr_isr;

  assign wr_commit = aw_valid_q & w_valid_q;
  assign wr_idx    = 32'(aw_word_q);
  // Only byte 0 of the control registers holds defined bits.
  assign wr_ctrl   = wr_commit & (wr_idx == CTRL_IDX) & wstrb_q[0];
  assign wr_gier   = wr_commit & (wr_idx == GIER_IDX) & wstrb_q[0];
  assign wr_ier    = wr_commit & (wr_idx == IER_IDX)  & wstrb_q[0];
  assign wr_isr    = wr_commit & (wr_idx == ISR_IDX)  & wstrb_q[0];

  // ---------------------------------------------------------------------------
  // Read decode, driven straight from araddr so rdata is captured at the
  // AR handshake edge.
  // ---------------------------------------------------------------------------
  int unsigned rd_idx;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_ctrl_hs;

  assign rd_idx     = 32'(s_axi_control_araddr[ADDR_W-1:2]);
  assign rd_ctrl_hs = ar_hs & (rd_idx == CTRL_IDX);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_idx == CTRL_IDX) begin
      rd_data = {24'b0, auto_restart_q, 3'b0, ready_q, ap_idle, done_q, ap_start_q};
    end else if (rd_idx == GIER_IDX) begin
      rd_data = {31'b0, gie_q};
    end else if (rd_idx == IER_IDX) begin
      rd_data = {30'b0, ier_q};
    end else if (rd_idx == ISR_IDX) begin
      rd_data = {30'b0, isr_q};
    end else if (rd_idx >= MAP_END) begin
      rd_resp = RESP_SLVERR;
    end else begin
      for (int unsigned i = 0; i < NUM_ARGS; i++) begin
        if (rd_idx == ARG_BASE + i) rd_data = args_q[i];
      end
      for (int unsigned j = 0; j < NUM_RESULTS; j++) begin
        if (rd_idx == RES_BASE + j) rd_data = results_q[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AXI channel sequencing
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ready_en_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_word_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;

      if (aw_hs) begin
        aw_valid_q <= 1'b1;
        aw_word_q  <= s_axi_control_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_valid_q <= 1'b1;
        wdata_q   <= s_axi_control_wdata;
        wstrb_q   <= s_axi_control_wstrb;
      end

      if (wr_commit) begin
        aw_valid_q <= 1'b0;
        w_valid_q  <= 1'b0;
        bvalid_q   <= 1'b1;
        bresp_q    <= (wr_idx < MAP_END) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axi_control_bready) begin
        bvalid_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi_control_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and kernel handshake.
  // Within this block a later assignment to the same bit takes priority, which
  // gives the set-wins behaviour for simultaneous hardware and host events.
  // ---------------------------------------------------------------------------
  // NOTE: args and results are a handful of flops, not RAM, so they are reset
  // along with the rest of the state to give the host a defined power-up view.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ap_start_q     <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      auto_restart_q <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= '0;
      isr_q          <= '0;
      for (int unsigned i = 0; i < NUM_ARGS; i++)    args_q[i]    <= '0;
      for (int unsigned j = 0; j < NUM_RESULTS; j++) results_q[j] <= '0;
    end else begin
      // ap_start: kernel acceptance clears it, auto-restart and host W1 set it.
      if (ap_ready)                  ap_start_q <= 1'b0;
      if (ap_done && auto_restart_q) ap_start_q <= 1'b1;
      if (wr_ctrl && wdata_q[0])     ap_start_q <= 1'b1;
      if (wr_ctrl)                   auto_restart_q <= wdata_q[7];

      // Sticky status bits, cleared by a CTRL read.
      if (rd_ctrl_hs) begin
        done_q  <= 1'b0;
        ready_q <= 1'b0;
      end
      if (ap_done)  done_q  <= 1'b1;
      if (ap_ready) ready_q <= 1'b1;

      if (wr_gier) gie_q <= wdata_q[0];
      if (wr_ier)  ier_q <= wdata_q[1:0];

      if (wr_isr)                isr_q    <= isr_q ^ wdata_q[1:0];
      if (ap_done  && ier_q[0])  isr_q[0] <= 1'b1;
      if (ap_ready && ier_q[1])  isr_q[1] <= 1'b1;

      if (ap_done) begin
        for (int unsigned j = 0; j < NUM_RESULTS; j++) begin
          results_q[j] <= results[32*j +: 32];
        end
      end

      if (wr_commit) begin
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
          if (wr_idx == ARG_BASE + i) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (wstrb_q[b]) args_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
    assign args[32*g +: 32] = args_q[g];
  end

  assign ap_start  = ap_start_q;
  assign interrupt = gie_q & (|isr_q);

endmodule
